mips_pipe_core: RTL

Parametrised five-stage MIPS pipeline core (IF, ID, EX, MEM, WB) with internal register file, EX-stage operand forwarding, load-use stall detection and branch flush. It runs dependent instruction streams correctly with no software-inserted NOPs. Instruction and data memories are external, with combinational read, so the core drops into the SoC between the code ROM and the data RAM.

---
 rtl/mips_pipe_core_if.sv | 38 +++
 rtl/mips_pipe_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipe_core_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mips_pipe_core_if : instruction/data memory, status and debug WB bus    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface mips_pipe_core_if #(
  parameter int PC_WIDTH       = 6,
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int CNT_WIDTH      = 16
);
  logic [PC_WIDTH-1:0]       imem_addr;
  logic [31:0]               imem_data;
  logic [DATA_WIDTH-1:0]     dmem_addr;
  logic [DATA_WIDTH-1:0]     dmem_wdata;
  logic                      dmem_we;
  logic                      dmem_re;
  logic [DATA_WIDTH-1:0]     dmem_rdata;
  logic                      stall;
  logic                      flush;
  logic                      wb_we;
  logic [REG_ADDR_WIDTH-1:0] wb_reg;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic [CNT_WIDTH-1:0]      retired;

  modport master (
    output imem_addr, dmem_addr, dmem_wdata, dmem_we, dmem_re,
           stall, flush, wb_we, wb_reg, wb_data, retired,
    input  imem_data, dmem_rdata
  );

  modport slave (
    input  imem_addr, dmem_addr, dmem_wdata, dmem_we, dmem_re,
           stall, flush, wb_we, wb_reg, wb_data, retired,
    output imem_data, dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mips_pipe_core.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mips_pipe_core : 5-stage MIPS subset pipeline, forwarding, stall, flush |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module mips_pipe_core #(
  parameter int PC_WIDTH       = 6,
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst,
  mips_pipe_core_if.master bus
);
  localparam int         NREGS    = 2**REG_ADDR_WIDTH;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef logic [REG_ADDR_WIDTH-1:0] ridx_t;
  typedef logic [DATA_WIDTH-1:0]     word_t;
  typedef logic [PC_WIDTH-1:0]       pc_t;
  typedef logic [CNT_WIDTH-1:0]      cnt_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  // Only the register-index bits the file can address are kept from fetch.
  typedef struct packed {
    logic [5:0]  op;
    ridx_t       rs;
    ridx_t       rt;
    logic [15:0] imm;
  } ifid_t;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic        use_imm;
    alu_op_e     alu_op;
    ridx_t       rs;
    ridx_t       rt;
    ridx_t       dest;
    word_t       rs_val;
    word_t       rt_val;
    logic [15:0] imm;
    pc_t         pc;
  } idex_t;

  typedef struct packed {
    logic  valid;
    logic  we;
    logic  is_lw;
    logic  is_sw;
    ridx_t dest;
    word_t alu;
    word_t sdata;
  } exmem_t;

  typedef struct packed {
    logic  valid;
    logic  we;
    ridx_t dest;
    word_t data;
  } memwb_t;

  pc_t    pc_q, pc_d, ifid_pc_q, ifid_pc_d;
  ifid_t  ifid_q, ifid_d;
  idex_t  idex_q, idex_d, id_ctl;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  cnt_t   retired_q;
  word_t  rf_q [NREGS];

  word_t       rs_rd, rt_rd, ex_a, ex_b, ex_rt, ex_res;
  logic [31:0] imm_ext;
  logic        id_uses_rt, stall, taken;
  pc_t         target;

  // EX/MEM never forwards a load: its ALU field holds the address, not the data.
  function automatic word_t fwd(ridx_t idx, word_t base, exmem_t em, memwb_t mw);
    if (idx != '0 && em.we && !em.is_lw && em.dest == idx) return em.alu;
    if (idx != '0 && mw.we && mw.dest == idx) return mw.data;
    return base;
  endfunction

  always_comb begin
    rs_rd = rf_q[ifid_q.rs];
    rt_rd = rf_q[ifid_q.rt];
    if (memwb_q.we && memwb_q.dest == ifid_q.rs) rs_rd = memwb_q.data;
    if (memwb_q.we && memwb_q.dest == ifid_q.rt) rt_rd = memwb_q.data;
    if (ifid_q.rs == '0) rs_rd = '0;
    if (ifid_q.rt == '0) rt_rd = '0;
  end

  always_comb begin
    id_ctl        = '0;
    id_uses_rt    = 1'b0;
    id_ctl.rs     = ifid_q.rs;
    id_ctl.rt     = ifid_q.rt;
    id_ctl.rs_val = rs_rd;
    id_ctl.rt_val = rt_rd;
    id_ctl.imm    = ifid_q.imm;
    id_ctl.pc     = ifid_pc_q;
    case (ifid_q.op)
      OP_RTYPE: begin
        id_uses_rt  = 1'b1;
        id_ctl.dest = ifid_q.imm[11 +: REG_ADDR_WIDTH];
        id_ctl.valid = 1'b1;
        case (ifid_q.imm[5:0])
          FN_ADD:  id_ctl.alu_op = ALU_ADD;
          FN_SUB:  id_ctl.alu_op = ALU_SUB;
          FN_AND:  id_ctl.alu_op = ALU_AND;
          FN_OR:   id_ctl.alu_op = ALU_OR;
          FN_SLT:  id_ctl.alu_op = ALU_SLT;
          default: id_ctl.valid  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        id_ctl.valid = 1'b1; id_ctl.use_imm = 1'b1; id_ctl.dest = ifid_q.rt;
      end
      OP_LW: begin
        id_ctl.valid = 1'b1; id_ctl.use_imm = 1'b1; id_ctl.is_lw = 1'b1;
        id_ctl.dest  = ifid_q.rt;
      end
      OP_SW: begin
        id_ctl.valid = 1'b1; id_ctl.use_imm = 1'b1; id_ctl.is_sw = 1'b1;
        id_uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        id_ctl.valid = 1'b1; id_ctl.is_beq = 1'b1; id_uses_rt = 1'b1;
      end
      default: ;
    endcase
    if (!id_ctl.valid) id_ctl.dest = '0;
    id_ctl.we = id_ctl.valid && (id_ctl.dest != '0);
  end

  assign stall = idex_q.is_lw && (idex_q.dest != '0) &&
                 ((idex_q.dest == ifid_q.rs) || (id_uses_rt && idex_q.dest == ifid_q.rt));

  always_comb begin
    imm_ext = {{16{idex_q.imm[15]}}, idex_q.imm};
    ex_a    = fwd(idex_q.rs, idex_q.rs_val, exmem_q, memwb_q);
    ex_rt   = fwd(idex_q.rt, idex_q.rt_val, exmem_q, memwb_q);
    ex_b    = idex_q.use_imm ? imm_ext[DATA_WIDTH-1:0] : ex_rt;
    case (idex_q.alu_op)
      ALU_SUB: ex_res = ex_a - ex_b;
      ALU_AND: ex_res = ex_a & ex_b;
      ALU_OR:  ex_res = ex_a | ex_b;
      ALU_SLT: ex_res = ($signed(ex_a) < $signed(ex_b)) ? word_t'(1) : '0;
      default: ex_res = ex_a + ex_b;
    endcase
    taken  = idex_q.is_beq && (ex_a == ex_rt);
    target = idex_q.pc + pc_t'(1) + imm_ext[PC_WIDTH-1:0];
  end

  always_comb begin
    exmem_d = '{valid: idex_q.valid, we: idex_q.we, is_lw: idex_q.is_lw,
                is_sw: idex_q.is_sw, dest: idex_q.dest, alu: ex_res, sdata: ex_rt};
    memwb_d = '{valid: exmem_q.valid, we: exmem_q.we, dest: exmem_q.dest,
                data: exmem_q.is_lw ? bus.dmem_rdata : exmem_q.alu};
  end

  // A taken branch outranks a load-use stall.
  always_comb begin
    pc_d       = pc_q + pc_t'(1);
    ifid_d.op  = bus.imem_data[31:26];
    ifid_d.rs  = bus.imem_data[21 +: REG_ADDR_WIDTH];
    ifid_d.rt  = bus.imem_data[16 +: REG_ADDR_WIDTH];
    ifid_d.imm = bus.imem_data[15:0];
    ifid_pc_d  = pc_q;
    idex_d     = id_ctl;
    if (taken) begin
      pc_d      = target;
      ifid_d    = '0;
      ifid_pc_d = '0;
      idex_d    = '0;
    end else if (stall) begin
      pc_d      = pc_q;
      ifid_d    = ifid_q;
      ifid_pc_d = ifid_pc_q;
      idex_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= '0;
      ifid_q    <= '0;
      ifid_pc_q <= '0;
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      retired_q <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      ifid_q    <= ifid_d;
      ifid_pc_q <= ifid_pc_d;
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      if (memwb_q.valid) retired_q <= retired_q + cnt_t'(1);
      if (memwb_q.we) rf_q[memwb_q.dest] <= memwb_q.data;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.dmem_addr  = exmem_q.alu;
  assign bus.dmem_wdata = exmem_q.sdata;
  assign bus.dmem_we    = exmem_q.is_sw;
  assign bus.dmem_re    = exmem_q.is_lw;
  assign bus.stall      = stall;
  assign bus.flush      = taken;
  assign bus.wb_we      = memwb_q.we;
  assign bus.wb_reg     = memwb_q.dest;
  assign bus.wb_data    = memwb_q.data;
  assign bus.retired    = retired_q;
endmodule
`default_nettype wire
